// File: rtl/mem_responder_if.sv
// Instruction/data bus bundle between a requester (master) and mem_responder (slave).
interface mem_responder_if;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output ireq, output dreq, input iresp, input dresp);
    modport slave  (input ireq, input dreq, output iresp, output dresp);

endinterface

// File: rtl/mem_responder.sv
// Single-port 64-bit memory responder for the core's ibus/dbus with fixed latency.
// dbus has strict priority; one transaction is in flight at a time.
module mem_responder #(
    parameter int unsigned WORDS   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic            err
);

    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_d;
    logic [63:0] lat_addr;
    logic [7:0]  lat_strobe;
    logic [63:0] lat_data;

    logic [63:0] mem [WORDS];

    logic        take;
    logic        cur_d;
    logic [63:0] cur_addr;
    logic [63:0] cur_off;
    logic [60:0] cur_idx;
    logic        cur_in;
    logic [63:0] cur_word;
    logic        enter_resp;

    // In IDLE the decode looks at the live request so LATENCY==1 can respond
    // straight from the acceptance edge; otherwise it uses the latched request.
    always_comb begin
        take       = bus.dreq.valid || bus.ireq.valid;
        cur_d      = (state == IDLE) ? bus.dreq.valid : lat_d;
        cur_addr   = lat_addr;
        if (state == IDLE)
            cur_addr = bus.dreq.valid ? bus.dreq.addr : bus.ireq.addr;
        cur_off    = cur_addr - BASE;
        cur_idx    = cur_off[63:3];
        cur_in     = (cur_addr >= BASE) && (cur_idx < 61'(WORDS));
        cur_word   = cur_in ? mem[cur_idx[AW-1:0]] : '0;
        enter_resp = ((state == IDLE) && take && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd1));
    end

    logic unused_bits;
    assign unused_bits = ^{bus.dreq.size, cur_off[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_d      <= 1'b0;
            lat_addr   <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
            err        <= 1'b0;
            bus.iresp  <= '0;
            bus.dresp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        lat_d      <= bus.dreq.valid;
                        lat_addr   <= cur_addr;
                        lat_strobe <= bus.dreq.valid ? bus.dreq.strobe : '0;
                        lat_data   <= bus.dreq.data;
                        cnt        <= CNT_LOAD;
                        state      <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    state     <= IDLE;
                    bus.iresp <= '0;
                    bus.dresp <= '0;
                end
                default: state <= IDLE;
            endcase

            // Response is registered on entry so it reads the pre-write word.
            if (enter_resp) begin
                if (cur_d) begin
                    bus.dresp.addr_ok <= 1'b1;
                    bus.dresp.data_ok <= 1'b1;
                    bus.dresp.data    <= cur_word;
                end else begin
                    bus.iresp.addr_ok <= 1'b1;
                    bus.iresp.data_ok <= 1'b1;
                    bus.iresp.data    <= cur_addr[2] ? cur_word[63:32] : cur_word[31:0];
                end
                if (!cur_in)
                    err <= 1'b1;
            end
        end
    end

    // Write commits on the edge that ends RESP; reset aborts it.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && lat_d && cur_in) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (lat_strobe[i])
                    mem[cur_idx[AW-1:0]][8*i +: 8] <= lat_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timeline/array model on a LATENCY=2 instance
// plus directed checks, and a LATENCY=4 instance for reset-during-flight.
module tb_mem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 1024;
    localparam int          L2    = 2;

    logic clk = 1'b0;
    logic rst2 = 1'b0;
    logic rst4 = 1'b0;
    logic err2, err4;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if bus2();
    mem_responder_if bus4();

    mem_responder #(.WORDS(WORDS), .LATENCY(2), .BASE(BASE)) dut2 (
        .clk(clk), .reset(rst2), .bus(bus2), .err(err2));
    mem_responder #(.WORDS(WORDS), .LATENCY(4), .BASE(BASE)) dut4 (
        .clk(clk), .reset(rst4), .bus(bus4), .err(err4));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of the LATENCY=2 instance ----------------
    logic [63:0] mm [longint];
    bit          m_init = 0, m_busy = 0, m_inresp = 0, m_d = 0, m_inr = 0, m_err = 0;
    int          m_rem = 0;
    logic [63:0] m_addr, m_data;
    logic [7:0]  m_strb;
    logic        e_dok = 0, e_iok = 0;
    logic [63:0] e_ddata = '0;
    logic [31:0] e_idata = '0;

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) / 8) < WORDS);
    endfunction

    task automatic start_resp();
        logic [63:0] w;
        m_inresp = 1;
        m_inr    = in_range(m_addr);
        w        = m_inr ? mm[longint'((m_addr - BASE) / 8)] : 64'd0;
        if (m_d) begin e_dok = 1; e_ddata = w; end
        else begin e_iok = 1; e_idata = m_addr[2] ? w[63:32] : w[31:0]; end
        if (!m_inr) m_err = 1;
    endtask

    always @(posedge clk) begin
        if (rst2) begin
            m_init = 1; m_busy = 0; m_inresp = 0; m_err = 0;
            e_dok = 0; e_iok = 0; e_ddata = '0; e_idata = '0;
        end else if (m_inresp) begin
            if (m_d && m_inr) begin
                logic [63:0] w;
                w = mm.exists(longint'((m_addr - BASE) / 8)) ? mm[longint'((m_addr - BASE) / 8)] : 64'd0;
                for (int i = 0; i < 8; i++)
                    if (m_strb[i]) w[8*i +: 8] = m_data[8*i +: 8];
                mm[longint'((m_addr - BASE) / 8)] = w;
            end
            m_inresp = 0; m_busy = 0;
            e_dok = 0; e_iok = 0; e_ddata = '0; e_idata = '0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) start_resp();
        end else if (bus2.dreq.valid || bus2.ireq.valid) begin
            m_d    = bus2.dreq.valid;
            m_addr = m_d ? bus2.dreq.addr : bus2.ireq.addr;
            m_strb = m_d ? bus2.dreq.strobe : 8'h00;
            m_data = bus2.dreq.data;
            m_busy = 1;
            m_rem  = L2 - 1;
            if (m_rem == 0) start_resp();
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst2) begin
            chk("d.addr_ok", 64'(bus2.dresp.addr_ok), 64'(e_dok));
            chk("d.data_ok", 64'(bus2.dresp.data_ok), 64'(e_dok));
            chk("d.data",    bus2.dresp.data,         e_ddata);
            chk("i.addr_ok", 64'(bus2.iresp.addr_ok), 64'(e_iok));
            chk("i.data_ok", 64'(bus2.iresp.data_ok), 64'(e_iok));
            chk("i.data",    64'(bus2.iresp.data),    64'(e_idata));
            chk("err",       64'(err2),               64'(m_err));
        end
    end

    // ---------------- requester tasks (called just after a negedge) ----------------
    task automatic idle2(input int n);
        bus2.dreq.valid = 0; bus2.ireq.valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_d2(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                         output logic [63:0] r, output int lat);
        int acc;
        bus2.ireq.valid = 0;
        bus2.dreq.valid = 1; bus2.dreq.addr = a; bus2.dreq.strobe = s;
        bus2.dreq.data = d; bus2.dreq.size = 3'd3;
        acc = cyc; r = '0; lat = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus2.dresp.data_ok) begin r = bus2.dresp.data; lat = cyc - acc; break; end
        end
        if (lat < 0) chk("d2_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_i2(input logic [63:0] a, output logic [63:0] r);
        bit seen = 0;
        bus2.dreq.valid = 0;
        bus2.ireq.valid = 1; bus2.ireq.addr = a;
        r = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus2.iresp.data_ok) begin r = 64'(bus2.iresp.data); seen = 1; break; end
        end
        if (!seen) chk("i2_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_d4(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                         output logic [63:0] r, output int lat);
        int acc;
        bus4.ireq.valid = 0;
        bus4.dreq.valid = 1; bus4.dreq.addr = a; bus4.dreq.strobe = s;
        bus4.dreq.data = d; bus4.dreq.size = 3'd3;
        acc = cyc; r = '0; lat = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus4.dresp.data_ok) begin r = bus4.dresp.data; lat = cyc - acc; break; end
        end
        if (lat < 0) chk("d4_timeout", 64'd0, 64'd1);
        bus4.dreq.valid = 0;
    endtask

    initial begin
        logic [63:0] r;
        int lat, t, d_at, i_at, both, hits;
        logic [63:0] i_data;
        bus2.dreq = '0; bus2.ireq = '0;
        bus4.dreq = '0; bus4.ireq = '0;

        @(negedge clk);
        rst2 = 1; rst4 = 1;
        repeat (2) @(negedge clk);
        rst2 = 0; rst4 = 0;
        idle2(10);
        chk("idle_outputs", {bus2.dresp.data_ok, bus2.iresp.data_ok, err2, bus2.dresp.data[60:0]}, 64'd0);

        // full write, readback, partial write, read-after-write back to back
        do_d2(BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, r, lat);
        chk("wr_latency", 64'(lat), 64'd2);
        idle2(1);
        do_d2(BASE + 64'h10, 8'h00, 64'h0, r, lat);
        chk("rd_full", r, 64'h1122_3344_5566_7788);
        do_d2(BASE + 64'h10, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, r, lat);
        chk("wr_prewrite_data", r, 64'h1122_3344_5566_7788);
        chk("b2b_latency", 64'(lat), 64'd3);
        do_d2(BASE + 64'h10, 8'h00, 64'h0, r, lat);
        chk("raw_partial", r, 64'h1122_3344_BBBB_BBBB);
        do_i2(BASE + 64'h14, r);
        chk("ibus_hi", r, 64'h1122_3344);
        do_i2(BASE + 64'h10, r);
        chk("ibus_lo", r, 64'hBBBB_BBBB);
        idle2(2);

        // first and last words
        do_d2(BASE, 8'hFF, 64'hCAFE_F00D_1234_5678, r, lat);
        do_d2(BASE + 64'h1FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, r, lat);
        do_d2(BASE + 64'h1FF8, 8'h00, 64'h0, r, lat);
        chk("last_word", r, 64'h0123_4567_89AB_CDEF);
        chk("err_in_range", 64'(err2), 64'd0);
        idle2(1);

        // simultaneous requests
        bus2.dreq.valid = 1; bus2.dreq.addr = BASE + 64'h10; bus2.dreq.strobe = 8'h00;
        bus2.ireq.valid = 1; bus2.ireq.addr = BASE + 64'h14;
        t = cyc; d_at = -1; i_at = -1; both = 0; i_data = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus2.dresp.data_ok && bus2.iresp.data_ok) both++;
            if (bus2.dresp.data_ok) begin d_at = cyc - t; bus2.dreq.valid = 0; end
            if (bus2.iresp.data_ok) begin i_at = cyc - t; i_data = 64'(bus2.iresp.data); bus2.ireq.valid = 0; end
        end
        chk("simul_d_at", 64'(d_at), 64'd2);
        chk("simul_i_at", 64'(i_at), 64'd5);
        chk("simul_both", 64'(both), 64'd0);
        chk("simul_i_data", i_data, 64'h1122_3344);

        // out of range
        do_d2(64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, r, lat);
        chk("oor_lo_latency", 64'(lat), 64'd2);
        chk("oor_lo_data", r, 64'd0);
        chk("oor_lo_err", 64'(err2), 64'd1);
        do_d2(BASE + 64'h1FF8, 8'h00, 64'h0, r, lat);
        chk("oor_lo_unchanged", r, 64'h0123_4567_89AB_CDEF);
        do_d2(BASE + 64'(8 * WORDS), 8'hFF, 64'h5555_5555_5555_5555, r, lat);
        do_d2(BASE + 64'(8 * WORDS), 8'h00, 64'h0, r, lat);
        chk("oor_hi_read", r, 64'd0);
        do_d2(BASE, 8'h00, 64'h0, r, lat);
        chk("oor_hi_no_wrap", r, 64'hCAFE_F00D_1234_5678);
        do_i2(BASE + 64'(8 * WORDS) + 64'h4, r);
        chk("oor_ibus", r, 64'd0);
        idle2(2);
        chk("err_sticky", 64'(err2), 64'd1);
        rst2 = 1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {err2, bus2.dresp.data_ok, bus2.iresp.data_ok}, 64'd0);
        rst2 = 0;
        idle2(1);
        chk("err_cleared", 64'(err2), 64'd0);
        do_d2(BASE + 64'h10, 8'h00, 64'h0, r, lat);
        chk("mem_kept_on_reset", r, 64'h1122_3344_BBBB_BBBB);
        idle2(2);

        // LATENCY=4 instance: reset during an in-flight write
        do_d4(BASE + 64'h40, 8'hFF, 64'h0BAD_C0DE_0BAD_C0DE, r, lat);
        chk("l4_latency", 64'(lat), 64'd4);
        @(negedge clk);
        bus4.dreq.valid = 1; bus4.dreq.addr = BASE + 64'h40;
        bus4.dreq.strobe = 8'hFF; bus4.dreq.data = 64'hFFFF_FFFF_FFFF_FFFF;
        hits = 0;
        @(negedge clk);
        if (bus4.dresp.data_ok || bus4.iresp.data_ok) hits++;
        @(negedge clk);
        if (bus4.dresp.data_ok || bus4.iresp.data_ok) hits++;
        rst4 = 1; bus4.dreq.valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) rst4 = 0;
            if (bus4.dresp.data_ok || bus4.iresp.data_ok) hits++;
        end
        chk("l4_no_data_ok", 64'(hits), 64'd0);
        do_d4(BASE + 64'h40, 8'h00, 64'h0, r, lat);
        chk("l4_write_aborted", r, 64'h0BAD_C0DE_0BAD_C0DE);
        chk("l4_err", 64'(err4), 64'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
